// File: rtl/mem_sys_ctrl.sv
// Handshaked memory-system access engine: decodes ROM / RAM / MMIO, inserts
// per-region wait states, steers byte lanes and flags illegal accesses.
//
// state  | meaning
// IDLE   | waiting for req_i; latches the request and loads the wait counter
// WAIT   | counting down wait states; result sampled when counter reaches 0
// DONE   | ready_o pulse with rdata_o/err_o; write has been committed
module mem_sys_ctrl #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RAM_BASE   = 32'h1000_0000,
  parameter int          RAM_DEPTH  = 64,
  parameter logic [31:0] MMIO_BASE  = 32'h7FFF_0000,
  parameter int          ROM_WAIT   = 1,
  parameter int          RAM_WAIT   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ready_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic [DATA_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  input  logic [DATA_WIDTH-1:0] gpio_in_i,
  output logic [DATA_WIDTH-1:0] gpio_out_o
);

  localparam int          AW         = $clog2(RAM_DEPTH);
  localparam logic [31:0] RAM_BYTES  = 32'(4 * RAM_DEPTH);
  localparam logic [3:0]  ROM_WAIT_C = 4'(ROM_WAIT);
  localparam logic [3:0]  RAM_WAIT_C = 4'(RAM_WAIT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;
  typedef enum logic [1:0] {RG_ROM, RG_RAM, RG_MMIO, RG_NONE} region_t;

  state_t      r_state, w_next_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata, r_gpio_out, r_cycle, r_rom_addr;
  logic        r_err;
  logic [31:0] r_ram [RAM_DEPTH];

  logic          w_accept, w_finish, w_commit;
  region_t       w_region;
  logic [31:0]   w_ram_off, w_mmio_off;
  logic [AW-1:0] w_ram_idx;
  logic [1:0]    w_mmio_idx, w_lane;
  logic          w_misalign, w_region_err, w_err;
  logic [31:0]   w_src, w_shifted, w_rdata;
  logic [3:0]    w_lane_en;
  logic [31:0]   w_wdata_sh, w_merged;

  assign rdata_o    = r_rdata;
  assign err_o      = r_err;
  assign rom_addr_o = r_rom_addr;
  assign gpio_out_o = r_gpio_out;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    ready_o      = 1'b0;
    busy_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          w_accept     = 1'b1;
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        busy_o = 1'b1;
        if (r_cnt == 4'd0) begin
          w_finish     = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        ready_o      = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Offsets wrap to large values below each base, so one compare bounds each window.
  assign w_ram_off  = r_addr - RAM_BASE;
  assign w_mmio_off = r_addr - MMIO_BASE;
  assign w_ram_idx  = w_ram_off[AW+1:2];
  assign w_mmio_idx = w_mmio_off[3:2];
  assign w_lane     = r_addr[1:0];

  always_comb begin
    w_region = RG_NONE;
    if (r_addr < RAM_BASE)
      w_region = RG_ROM;
    else if (w_ram_off < RAM_BYTES)
      w_region = RG_RAM;
    else if (w_mmio_off < 32'd16)
      w_region = RG_MMIO;
  end

  always_comb begin
    w_misalign   = 1'b0;
    w_region_err = 1'b0;
    case (r_size)
      2'b01:   w_misalign = w_lane[0];
      2'b10:   w_misalign = |w_lane;
      default: w_misalign = 1'b0;
    endcase
    case (w_region)
      RG_ROM:  w_region_err = r_we;
      RG_RAM:  w_region_err = 1'b0;
      RG_MMIO: w_region_err = (r_size != 2'b10) || (w_mmio_idx == 2'd3) ||
                              (r_we && (w_mmio_idx != 2'd0));
      default: w_region_err = 1'b1;
    endcase
    w_err = (r_size == 2'b11) || w_misalign || w_region_err;
  end

  always_comb begin
    w_src = '0;
    case (w_region)
      RG_ROM:  w_src = rom_data_i;
      RG_RAM:  w_src = r_ram[w_ram_idx];
      RG_MMIO: begin
        case (w_mmio_idx)
          2'd0:    w_src = r_gpio_out;
          2'd1:    w_src = gpio_in_i;
          // value the counter holds during the DONE cycle
          2'd2:    w_src = r_cycle + 32'd1;
          default: w_src = '0;
        endcase
      end
      default: w_src = '0;
    endcase

    w_shifted = w_src >> {w_lane, 3'b000};
    w_rdata   = w_shifted;
    w_lane_en = 4'b1111;
    case (r_size)
      2'b00: begin
        w_rdata   = {24'd0, w_shifted[7:0]};
        w_lane_en = 4'b0001 << w_lane;
      end
      2'b01: begin
        w_rdata   = {16'd0, w_shifted[15:0]};
        w_lane_en = 4'b0011 << w_lane;
      end
      default: begin
        w_rdata   = w_shifted;
        w_lane_en = 4'b1111;
      end
    endcase

    w_wdata_sh = r_wdata << {w_lane, 3'b000};
    w_merged   = w_src;
    for (int i = 0; i < 4; i++) begin
      if (w_lane_en[i])
        w_merged[8*i +: 8] = w_wdata_sh[8*i +: 8];
    end
  end

  assign w_commit = w_finish && !w_err && r_we && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= 4'd0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_gpio_out <= '0;
      r_cycle    <= '0;
      r_rom_addr <= '0;
    end else begin
      r_state <= w_next_state;
      r_cycle <= r_cycle + 32'd1;
      if (w_accept) begin
        r_we       <= we_i;
        r_size     <= size_i;
        r_addr     <= addr_i;
        r_wdata    <= wdata_i;
        r_rom_addr <= addr_i & ~32'h3;
        r_cnt      <= (addr_i < RAM_BASE) ? ROM_WAIT_C : RAM_WAIT_C;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_finish) begin
        r_err   <= w_err;
        r_rdata <= w_err ? '0 : w_rdata;
        if (w_commit && (w_region == RG_MMIO))
          r_gpio_out <= r_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && (w_region == RG_RAM))
      r_ram[w_ram_idx] <= w_merged;
  end

endmodule

// File: tb/tb_mem_sys_ctrl.sv
// Bench for mem_sys_ctrl: directed cases plus random traffic checked against a
// byte-addressed reference model of the memory map.
module tb_mem_sys_ctrl;
  localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
  localparam int          RAM_DEPTH = 64;
  localparam logic [31:0] MMIO_BASE = 32'h7FFF_0000;
  localparam int          ROM_WAIT  = 1;
  localparam int          RAM_WAIT  = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_i, we_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i, rdata_o, rom_addr_o, rom_data_i, gpio_in_i, gpio_out_o;
  logic        ready_o, err_o, busy_o;

  always #5 clk = ~clk;

  mem_sys_ctrl #(
    .DATA_WIDTH(32), .RAM_BASE(RAM_BASE), .RAM_DEPTH(RAM_DEPTH),
    .MMIO_BASE(MMIO_BASE), .ROM_WAIT(ROM_WAIT), .RAM_WAIT(RAM_WAIT)
  ) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .ready_o(ready_o),
    .err_o(err_o), .busy_o(busy_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .gpio_in_i(gpio_in_i), .gpio_out_o(gpio_out_o)
  );

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    if (a == 32'h4) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  assign rom_data_i = rom_f(rom_addr_o);

  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  m_ram_b [4*RAM_DEPTH];
  logic [31:0] m_gpio;
  logic [31:0] m_cycle;

  always @(posedge clk) begin
    if (reset) m_cycle <= 32'd0;
    else       m_cycle <= m_cycle + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Memory map as a programmer sees it: byte array for RAM, named MMIO words.
  task automatic ref_access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic err, output logic [31:0] rd);
    int          nb;
    logic [31:0] off;
    err = 1'b0;
    rd  = 32'd0;
    nb  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    if (size == 2'b11 || (addr % 32'(nb)) != 32'd0) begin
      err = 1'b1;
    end else if (addr < RAM_BASE) begin
      if (we) err = 1'b1;
      else    rd = rom_f(addr & ~32'h3) >> (8 * addr[1:0]);
    end else if (addr - RAM_BASE < 32'(4 * RAM_DEPTH)) begin
      off = addr - RAM_BASE;
      for (int i = 0; i < nb; i++) begin
        if (we) m_ram_b[off + 32'(i)] = wdata[8*i +: 8];
        else    rd |= 32'(m_ram_b[off + 32'(i)]) << (8 * i);
      end
    end else if (addr >= MMIO_BASE && addr - MMIO_BASE < 32'd16) begin
      off = addr - MMIO_BASE;
      if (nb != 4) err = 1'b1;
      else case (off)
        32'd0: if (we) m_gpio = wdata; else rd = m_gpio;
        32'd4: if (we) err = 1'b1; else rd = gpio_in_i;
        32'd8: if (we) err = 1'b1; else rd = m_cycle;
        default: err = 1'b1;
      endcase
    end else begin
      err = 1'b1;
    end
    if (nb == 1) rd &= 32'h0000_00FF;
    if (nb == 2) rd &= 32'h0000_FFFF;
    if (err) rd = 32'd0;
  endtask

  task automatic txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic hold, input string tag,
                     output logic [31:0] rd, output logic [31:0] rcyc);
    int          n;
    int          w;
    logic        e_err;
    logic [31:0] e_rd;
    w = (addr < RAM_BASE) ? ROM_WAIT : RAM_WAIT;
    @(negedge clk);
    chk({tag, "/idle"}, {31'd0, busy_o}, 32'd0);
    req_i = 1'b1; we_i = we; size_i = size; addr_i = addr; wdata_i = wdata;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "/busy"}, {31'd0, busy_o}, 32'd1);
    if (!hold) req_i = 1'b0;
    we_i = 1'($urandom); size_i = 2'($urandom); addr_i = $urandom; wdata_i = $urandom;
    n = 0;
    while (!ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/latency"}, 32'(n), 32'(w + 1));
    ref_access(we, size, addr, wdata, e_err, e_rd);
    chk({tag, "/err"}, {31'd0, err_o}, {31'd0, e_err});
    if (!we || e_err) chk({tag, "/rdata"}, rdata_o, e_rd);
    chk({tag, "/gpio"}, gpio_out_o, m_gpio);
    chk({tag, "/rom_addr"}, rom_addr_o, addr & ~32'h3);
    rd   = rdata_o;
    rcyc = m_cycle;
  endtask

  task automatic err_case(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
    logic [31:0] rd, c;
    txn(we, size, addr, wdata, 1'b0, tag, rd, c);
    chk({tag, "/err_flag"}, {31'd0, err_o}, 32'd1);
    chk({tag, "/zero"}, rd, 32'd0);
  endtask

  task automatic abort_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input int nwait, input string tag);
    @(negedge clk);
    req_i = 1'b1; we_i = we; size_i = size; addr_i = addr; wdata_i = wdata;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0;
    repeat (nwait) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    m_gpio = 32'd0;
    chk({tag, "/ready"}, {31'd0, ready_o}, 32'd0);
    chk({tag, "/busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "/gpio"}, gpio_out_o, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({tag, "/no_ready"}, {31'd0, ready_o}, 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, rd0, c, c0, c1, a;
    logic [1:0]  sz;
    req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; addr_i = 32'd0; wdata_i = 32'd0;
    gpio_in_i = 32'd0; m_gpio = 32'd0; reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst/ready", {31'd0, ready_o}, 32'd0);
    chk("rst/err", {31'd0, err_o}, 32'd0);
    chk("rst/busy", {31'd0, busy_o}, 32'd0);
    chk("rst/rdata", rdata_o, 32'd0);
    chk("rst/gpio", gpio_out_o, 32'd0);
    chk("rst/rom_addr", rom_addr_o, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < RAM_DEPTH; i++)
      txn(1'b1, 2'b10, RAM_BASE + 32'(4 * i), $urandom, 1'b0, "fill", rd, c);

    txn(1'b0, 2'b10, 32'h0000_0004, 32'd0, 1'b0, "rom_word", rd, c);
    chk("rom_word/value", rd, 32'h2008_0005);
    txn(1'b0, 2'b00, 32'h0000_0006, 32'd0, 1'b0, "rom_byte", rd, c);

    txn(1'b1, 2'b10, 32'h1000_0010, 32'h1122_3344, 1'b0, "merge_w", rd, c);
    txn(1'b1, 2'b00, 32'h1000_0012, 32'h0000_00AA, 1'b0, "merge_b", rd, c);
    txn(1'b1, 2'b01, 32'h1000_0010, 32'h0000_BEEF, 1'b0, "merge_h", rd, c);
    txn(1'b0, 2'b10, 32'h1000_0010, 32'd0, 1'b0, "merge_rd", rd, c);
    chk("merge_rd/value", rd, 32'h11AA_BEEF);
    txn(1'b0, 2'b00, 32'h1000_0013, 32'd0, 1'b0, "byte_rd", rd, c);
    chk("byte_rd/value", rd, 32'h0000_0011);

    txn(1'b1, 2'b10, MMIO_BASE, 32'hDEAD_BEEF, 1'b0, "gpio_wr", rd, c);
    chk("gpio_wr/value", gpio_out_o, 32'hDEAD_BEEF);
    gpio_in_i = 32'h5A5A_0001;
    txn(1'b0, 2'b10, MMIO_BASE + 32'h4, 32'd0, 1'b0, "gpio_rd", rd, c);
    chk("gpio_rd/value", rd, 32'h5A5A_0001);
    txn(1'b0, 2'b10, MMIO_BASE + 32'h8, 32'd0, 1'b0, "cyc_a", rd0, c);
    repeat (5) @(negedge clk);
    txn(1'b0, 2'b10, MMIO_BASE + 32'h8, 32'd0, 1'b0, "cyc_b", rd, c);
    chk("cycle_delta", rd - rd0, 32'd8);

    err_case(1'b0, 2'b10, 32'h1000_0002, 32'd0, "e_word_mis");
    err_case(1'b0, 2'b01, 32'h1000_0001, 32'd0, "e_half_mis");
    err_case(1'b1, 2'b10, 32'h0000_0000, 32'h1234_5678, "e_rom_wr");
    err_case(1'b0, 2'b10, 32'h2000_0000, 32'd0, "e_unmapped");
    err_case(1'b1, 2'b11, 32'h1000_0010, 32'hFFFF_FFFF, "e_size11");
    err_case(1'b1, 2'b00, MMIO_BASE, 32'h0000_0055, "e_mmio_byte");
    err_case(1'b1, 2'b10, MMIO_BASE + 32'h8, 32'h0000_0001, "e_cycle_wr");
    err_case(1'b0, 2'b10, MMIO_BASE + 32'hC, 32'd0, "e_reserved");
    txn(1'b0, 2'b10, 32'h1000_0010, 32'd0, 1'b0, "after_err", rd, c);
    chk("after_err/ram", rd, 32'h11AA_BEEF);
    chk("after_err/gpio", gpio_out_o, 32'hDEAD_BEEF);

    abort_txn(1'b0, 2'b10, 32'h0000_0008, 32'd0, 1, "abort_rom");
    abort_txn(1'b1, 2'b10, 32'h1000_0010, 32'hCAFE_F00D, 0, "abort_ram");
    txn(1'b0, 2'b10, 32'h1000_0010, 32'd0, 1'b0, "after_abort", rd, c);
    chk("after_abort/ram", rd, 32'h11AA_BEEF);

    txn(1'b1, 2'b10, 32'h1000_0020, 32'h0BAD_CAFE, 1'b1, "b2b_0", rd, c0);
    txn(1'b0, 2'b10, 32'h1000_0020, 32'd0, 1'b1, "b2b_1", rd, c1);
    chk("b2b_1/spacing", c1 - c0, 32'd3);
    chk("b2b_1/value", rd, 32'h0BAD_CAFE);
    txn(1'b0, 2'b00, 32'h1000_0021, 32'd0, 1'b1, "b2b_2", rd, c);
    req_i = 1'b0;
    chk("b2b_2/spacing", c - c1, 32'd3);
    chk("b2b_2/value", rd, 32'h0000_00CA);

    for (int i = 0; i < 300; i++) begin
      gpio_in_i = $urandom;
      case ($urandom_range(0, 5))
        0:       a = 32'($urandom_range(0, 255));
        1, 2:    a = RAM_BASE + 32'($urandom_range(0, 4 * RAM_DEPTH - 1));
        3:       a = MMIO_BASE + 32'($urandom_range(0, 15));
        4:       a = 32'h2000_0000 + 32'($urandom_range(0, 1023));
        default: a = RAM_BASE + 32'(4 * RAM_DEPTH) + 32'($urandom_range(0, 63));
      endcase
      sz = 2'($urandom_range(0, 3));
      txn(1'($urandom), sz, a, $urandom, 1'b0, "rand", rd, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_sys_ctrl.md
Name: mem_sys_ctrl

Overview:
Parametrised memory-system controller for the multicycle MIPS core. It replaces the combinational ROM/RAM select with a registered, handshaked access engine. The engine decodes each address into one of three regions: external ROM, internal data RAM, or a small MMIO block. It supports per-region wait states, byte/half/word accesses with byte-lane steering, and error signalling. It sits between the core's memory-interface FSM and the instruction ROM.

Parameters:
DATA_WIDTH, 32, data/address width (fixed 32 for byte-lane logic)
RAM_BASE, 32'h1000_0000, first RAM byte address; addresses below it decode to ROM
RAM_DEPTH, 64, RAM size in 32-bit words (power of 2)
MMIO_BASE, 32'h7FFF_0000, base of MMIO block (16 bytes)
ROM_WAIT, 1, extra wait cycles for ROM accesses (0..15)
RAM_WAIT, 0, extra wait cycles for RAM and MMIO accesses (0..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_i  in  1  access request, sampled only when busy_o=0
we_i  in  1  1=write, 0=read
size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
addr_i  in  32  byte address
wdata_i  in  32  write data, right-aligned (byte in [7:0], half in [15:0])
rdata_o  out  32  read data, zero-extended, right-aligned; valid when ready_o=1
ready_o  out  1  one-cycle completion pulse
err_o  out  1  error flag, valid with ready_o
busy_o  out  1  transaction in flight
rom_addr_o  out  32  word-aligned ROM address (latched addr & ~3)
rom_data_i  in  32  combinational ROM word
gpio_in_i  in  32  external input port
gpio_out_o  out  32  MMIO output register

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE; ready_o=0, err_o=0, busy_o=0, rdata_o=0, gpio_out_o=0, cycle counter=0, rom_addr_o=0. RAM contents are not reset.
- Reset mid-transaction aborts the access. Any pending write is discarded. No ready_o pulse is issued for the aborted access.
- Decode, in priority order:
  - addr < RAM_BASE -> ROM.
  - RAM_BASE <= addr < RAM_BASE+4*RAM_DEPTH -> RAM.
  - MMIO_BASE+0x0 GPIO_OUT (rw), +0x4 GPIO_IN (ro), +0x8 CYCLE (ro, free-running 32-bit cycle count, wraps 0xFFFF_FFFF->0), +0xC reserved.
  - Anything else -> unmapped.
- FSM states:
  - IDLE: busy_o=0. If req_i=1, latch we/size/addr/wdata, load the wait counter with the region's wait value, set busy_o=1, go to WAIT. Unmapped accesses use RAM_WAIT.
  - WAIT: decrement the counter. When counter==0, go to DONE. With 0 wait states, WAIT lasts exactly one cycle.
  - DONE: ready_o=1 for this single cycle, plus rdata_o/err_o. A write commits at this edge. busy_o=0 here, then return to IDLE. A new request is accepted no earlier than the cycle after DONE.
- Latency: request accepted at edge N gives ready_o high in cycle N+2+WAIT.
- Request changes while busy_o=1 are ignored. Inputs latched at acceptance are used throughout the transaction.
- Lane rules (little-endian): the byte at addr[1:0]=k occupies wdata/RAM bits [8k+7:8k].
  - Byte: any alignment.
  - Half: addr[0]=0 required.
  - Word: addr[1:0]=0 required.
  - Reads shift the selected lanes to the LSBs and zero the upper bits.
  - Writes update only the selected lanes of the RAM word; other bytes are preserved.
  - MMIO registers accept only word access.
- Error conditions: err_o=1 with ready_o, rdata_o=0, and no state change occurs when any of these holds:
  - size 11
  - misalignment
  - write to ROM, GPIO_IN, CYCLE, or reserved
  - any access to unmapped or reserved space
  - non-word MMIO access
- rdata_o and err_o hold their values after DONE until the next DONE. rdata_o is cleared on error.
- RAM: internal reg array of RAM_DEPTH words, indexed by (addr-RAM_BASE)>>2.
- CYCLE: increments every clock, including during accesses. A read returns the value sampled in the DONE cycle.

Test Plan:
- Reset mid-WAIT: start a ROM read (ROM_WAIT=3), assert reset in the second WAIT cycle -> no ready_o pulse; busy_o=0 and gpio_out_o=0 next cycle.
- ROM read: addr 0x0000_0004, rom_data_i=0x2008_0005, ROM_WAIT=1 -> ready_o high 3 cycles after acceptance, rdata_o=0x2008_0005, err_o=0, rom_addr_o=0x4.
- RAM byte/half merge:
  - Word write 0x1122_3344 to 0x1000_0010.
  - Byte write 0xAA to 0x1000_0012.
  - Half write 0xBEEF to 0x1000_0010.
  - Word read -> 0x11AA_BEEF.
  - Byte read of 0x1000_0013 -> 0x0000_0011.
- Errors: each of the following -> err_o=1, rdata_o=0, and RAM/GPIO unchanged:
  - word read at 0x1000_0002
  - half at 0x1000_0001
  - write to 0x0000_0000
  - read at 0x2000_0000
  - size 11
  - byte write to MMIO_BASE
- MMIO: word write 0xDEAD_BEEF to MMIO_BASE -> gpio_out_o=0xDEAD_BEEF. Read MMIO_BASE+4 with gpio_in_i=0x5A5A_0001 -> 0x5A5A_0001. Two CYCLE reads spaced k cycles apart -> difference equals k.
- Back-to-back requests: req_i held high for 3 transactions with RAM_WAIT=0 -> ready_o pulses every 3 cycles; inputs changed mid-transaction have no effect.
